// File: rtl/dram_phase_arbiter.sv
// dram_phase_arbiter: sequences the image DRAM through load -> process -> dump
// phases and arbitrates the rx writer, downsampler read/write ports and the
// tx retriever onto the single DRAM port.
// Optional feature macro: DRAM_ARB_DEBUG_PORT_EN (drives ram_addr from dbg_addr in IDLE).
module dram_phase_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [ADDR_W-1:0] req_addr3,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata2,
    output logic [3:0]        gnt,
    output logic [3:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              load_done,
    input  logic              proc_done,
    input  logic              dump_done,
    input  logic              start_dump,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        phase,
    output logic [15:0]       xfer_count,
    input  logic [ADDR_W-1:0] dbg_addr
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NREQ  = 4;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        PROC = 2'b01,
        IDLE = 2'b10,
        DUMP = 2'b11
    } state_e;

    // Read-capable ports whose grants produce a delayed rd_valid pulse
    localparam logic [NREQ-1:0] RD_PORTS = 4'b1010;

    state_e            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic              dump_pend_q, dump_pend_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

`ifndef DRAM_ARB_DEBUG_PORT_EN
    // Debug address only feeds the DRAM when the debug port is built in
    logic unused_dbg_addr;
    assign unused_dbg_addr = ^dbg_addr;
`endif

    // Phase sequencing, per-phase arbitration and DRAM command selection
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        dump_pend_d  = dump_pend_q | start_dump;
        gnt_d        = '0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        rd_valid_d   = gnt_q & RD_PORTS;
        xfer_count_d = xfer_count_q;

        case (state_q)
            LOAD: begin
                gnt_d[0] = req[0];
                if (load_done) state_d = PROC;
            end
            PROC: begin
                if (req[1] && req[2]) begin
                    if (last_q == 2'd2) gnt_d[1] = 1'b1;
                    else                gnt_d[2] = 1'b1;
                end else begin
                    gnt_d[1] = req[1];
                    gnt_d[2] = req[2];
                end
                if (gnt_d[1])      last_d = 2'd1;
                else if (gnt_d[2]) last_d = 2'd2;
                if (proc_done) state_d = IDLE;
            end
            IDLE: begin
                if (dump_pend_q) begin
                    state_d     = DUMP;
                    dump_pend_d = start_dump;
                end
            end
            DUMP: begin
                gnt_d[3] = req[3];
                if (dump_done) state_d = IDLE;
            end
            default: state_d = LOAD;
        endcase

        if (gnt_d[0]) begin
            ram_addr_d  = req_addr0;
            ram_wdata_d = req_wdata0;
            ram_we_d    = 1'b1;
        end else if (gnt_d[1]) begin
            ram_addr_d  = req_addr1;
        end else if (gnt_d[2]) begin
            ram_addr_d  = req_addr2;
            ram_wdata_d = req_wdata2;
            ram_we_d    = 1'b1;
        end else if (gnt_d[3]) begin
            ram_addr_d  = req_addr3;
`ifdef DRAM_ARB_DEBUG_PORT_EN
        end else if (state_q == IDLE) begin
            ram_addr_d  = dbg_addr;
`endif
        end

        if (state_d != state_q)  xfer_count_d = '0;
        else if (|gnt_d)         xfer_count_d = xfer_count_q + CNT_W'(1);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            last_q       <= 2'd2;
            dump_pend_q  <= 1'b0;
            gnt_q        <= '0;
            rd_valid_q   <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            dump_pend_q  <= dump_pend_d;
            gnt_q        <= gnt_d;
            rd_valid_q   <= rd_valid_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign gnt        = gnt_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = ram_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign phase      = state_q;
    assign xfer_count = xfer_count_q;

endmodule
